alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Writeback/commit stage directly downstream of the 8-bit ALU.
- Accepts each ALU result with its opcode, destination register and condition code over a valid/ready handshake, and buffers it in a 2-entry skid FIFO toward the register-file write port.
- Owns the architectural flags register (Z,N,C,V) and evaluates the branch condition of each transaction against the committed flags.

Parameters:
- W, 8, datapath width; must match the ALU result width.
- RD_W, 2, destination register index width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  synchronous active-low reset.
- valid_i  in  1  upstream transaction valid.
- ready_o  out  1  stage can accept a transaction this cycle.
- r_i  in  W  ALU result.
- flags_i  in  4  ALU flags: [3]=Z, [2]=N, [1]=C, [0]=V.
- op_i  in  3  ALU opcode: 0=A, 1=ADD, 2=SUB, 3=MUL, 4=AND, 5=OR, 6=XOR, 7=NOT.
- rd_i  in  RD_W  destination register.
- cond_i  in  3  branch condition code.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  register file / consumer accepts the head entry.
- wb_data_o  out  W  head entry data.
- wb_rd_o  out  RD_W  head entry destination register.
- wb_taken_o  out  1  head entry branch-condition result.
- flags_q_o  out  4  committed flags register.
- count_o  out  2  FIFO occupancy, 0..2.

Behaviour:
- Reset (rst_ni low at a clock edge): count=0; flags_q=4'b0000; all FIFO entries cleared.
  - Outputs while in reset: wb_valid_o=0, wb_data_o=0, wb_rd_o=0, wb_taken_o=0.
  - valid_i and wb_ready_i are ignored during reset.
  - Reset mid-operation discards all buffered entries; nothing is written back.
- ready_o = (count != 2).
  - Depends only on registered state; there is no combinational path from wb_ready_i.
- Accept = valid_i && ready_o. Pop = wb_valid_o && wb_ready_i.
- wb_valid_o = (count != 0). The head entry drives wb_data_o, wb_rd_o and wb_taken_o.
  - These outputs hold stable while wb_valid_o=1 and wb_ready_i=0.
- Latency: a transaction accepted in cycle t appears at the head in cycle t+1 if the FIFO was empty at t.
- Throughput: 1 transaction per cycle when the consumer is always ready.
- Occupancy update:
  - Accept only: count+1.
  - Pop only: count-1.
  - Accept and pop in the same cycle: count unchanged.
    - At count=1, the new entry becomes head on the next cycle.
    - At count=0, a same-cycle pop cannot occur.
  - At count=2 accept is impossible; a pop frees one slot, visible as ready_o=1 on the next cycle.
- FIFO ordering is strict; implement as 2 registers with read/write pointers or as head/tail shift. Either is acceptable provided ordering holds.
- Branch evaluation uses flags_q as it stands before this transaction's flag update. The result is stored with the entry.
  - cond_i 0 = always 1.
  - 1 = EQ, Z.
  - 2 = NE, !Z.
  - 3 = MI, N.
  - 4 = PL, !N.
  - 5 = CS, C.
  - 6 = VS, V.
  - 7 = never 0.
- Flag update, on accept only:
  - op ADD or SUB: flags_q <= flags_i (all four).
  - All other ops: Z <= (r_i == 0) and N <= r_i[W-1], both recomputed from r_i and not taken from flags_i; C and V are held.
  - No accept: flags_q is held.
- Back-to-back accepts: each transaction's condition sees the flags committed by the previous accepted transaction. There is no forwarding of the same-cycle flags.
- flags_q_o = flags_q, registered.

Test Plan:
- Reset then idle: after reset, ready_o=1, wb_valid_o=0, flags_q_o=0, count_o=0. Asserting valid_i while rst_ni=0 produces no entry.
- Single ADD, result 0x00 with flags_i=4'b1010: op=1, r_i=0x00, rd=2, cond=0 -> next cycle wb_valid_o=1, wb_data_o=0x00, wb_rd_o=2, wb_taken_o=1; flags_q_o=4'b1010.
- Logic op preserves C/V: with flags_q=4'b0010, accept op=AND, r_i=0x80, flags_i=4'b1111 -> flags_q_o=4'b0110.
- Condition ordering: with flags_q=0, accept SUB (flags_i=4'b1000, cond=EQ) then op=A (cond=EQ) back-to-back -> first entry wb_taken_o=0, second entry wb_taken_o=1.
- Backpressure: wb_ready_i=0 while sending 3 transactions (data 0x11, 0x22, 0x33) -> count_o reaches 2, ready_o=0, third is held upstream. Then wb_ready_i=1 -> outputs 0x11, 0x22, 0x33 in order, one per cycle after the third is accepted.
- Simultaneous push/pop at count=1, then reset with 2 entries buffered: count_o stays 1 with order preserved. Reset -> count_o=0, wb_valid_o=0, and the discarded entries never appear.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Writeback/commit stage behind the 8-bit ALU.
// Buffers ALU results in a 2-entry skid FIFO toward the register-file write
// port, owns the architectural flags register and tags each entry with its
// branch-condition result evaluated against the committed flags.
module alu_wb_stage #(
    parameter int W    = 8,
    parameter int RD_W = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [W-1:0]    r_i,
    input  logic [3:0]      flags_i,
    input  logic [2:0]      op_i,
    input  logic [RD_W-1:0] rd_i,
    input  logic [2:0]      cond_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [W-1:0]    wb_data_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic            wb_taken_o,
    output logic [3:0]      flags_q_o,
    output logic [1:0]      count_o
);

    typedef enum logic [2:0] {
        OP_A   = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOT = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        CC_AL = 3'd0,
        CC_EQ = 3'd1,
        CC_NE = 3'd2,
        CC_MI = 3'd3,
        CC_PL = 3'd4,
        CC_CS = 3'd5,
        CC_VS = 3'd6,
        CC_NV = 3'd7
    } cond_e;

    // Slot 0 is always the head; slot 1 holds the second entry when count=2.
    logic [W-1:0]    data_q [2];
    logic [RD_W-1:0] rd_q   [2];
    logic            taken_q[2];
    logic [1:0]      count_q;
    logic [3:0]      flags_q;

    logic            accept;
    logic            pop;
    logic            taken_d;
    logic [3:0]      flags_d;
    op_e             op;

    assign op      = op_e'(op_i);
    assign ready_o = (count_q != 2'd2);
    assign accept  = valid_i && ready_o;
    assign pop     = wb_valid_o && wb_ready_i;

    // Head outputs, forced to zero whenever no entry is presented or reset is held.
    always_comb begin
        wb_valid_o = rst_ni && (count_q != 2'd0);
        wb_data_o  = '0;
        wb_rd_o    = '0;
        wb_taken_o = 1'b0;
        if (wb_valid_o) begin
            wb_data_o  = data_q[0];
            wb_rd_o    = rd_q[0];
            wb_taken_o = taken_q[0];
        end
    end

    // Branch condition against the flags committed before this transaction.
    always_comb begin
        taken_d = 1'b0;
        case (cond_e'(cond_i))
            CC_AL: taken_d = 1'b1;
            CC_EQ: taken_d = flags_q[3];
            CC_NE: taken_d = !flags_q[3];
            CC_MI: taken_d = flags_q[2];
            CC_PL: taken_d = !flags_q[2];
            CC_CS: taken_d = flags_q[1];
            CC_VS: taken_d = flags_q[0];
            CC_NV: taken_d = 1'b0;
            default: taken_d = 1'b0;
        endcase
    end

    // Next flags: arithmetic ops commit ALU flags, others recompute Z/N and hold C/V.
    always_comb begin
        flags_d = flags_q;
        if (accept) begin
            if (op == OP_ADD || op == OP_SUB) begin
                flags_d = flags_i;
            end else begin
                flags_d = {(r_i == '0), r_i[W-1], flags_q[1:0]};
            end
        end
    end

    // FIFO storage, occupancy and flags register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            flags_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i]  <= '0;
                rd_q[i]    <= '0;
                taken_q[i] <= 1'b0;
            end
        end else begin
            flags_q <= flags_d;
            case ({accept, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        data_q[0]  <= r_i;
                        rd_q[0]    <= rd_i;
                        taken_q[0] <= taken_d;
                    end else begin
                        data_q[1]  <= r_i;
                        rd_q[1]    <= rd_i;
                        taken_q[1] <= taken_d;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    data_q[0]  <= data_q[1];
                    rd_q[0]    <= rd_q[1];
                    taken_q[0] <= taken_q[1];
                    data_q[1]  <= '0;
                    rd_q[1]    <= '0;
                    taken_q[1] <= 1'b0;
                    count_q    <= count_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable at count=1: the new entry replaces the popped head.
                    data_q[0]  <= r_i;
                    rd_q[0]    <= rd_i;
                    taken_q[0] <= taken_d;
                end
                default: ;
            endcase
        end
    end

    assign flags_q_o = flags_q;
    assign count_o   = count_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Testbench for alu_wb_stage: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_alu_wb_stage;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] r_i;
    logic [3:0] flags_i;
    logic [2:0] op_i;
    logic [1:0] rd_i;
    logic [2:0] cond_i;
    logic       wb_valid_o;
    logic       wb_ready_i;
    logic [7:0] wb_data_o;
    logic [1:0] wb_rd_o;
    logic       wb_taken_o;
    logic [3:0] flags_q_o;
    logic [1:0] count_o;

    alu_wb_stage #(.W(8), .RD_W(2)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .r_i        (r_i),
        .flags_i    (flags_i),
        .op_i       (op_i),
        .rd_i       (rd_i),
        .cond_i     (cond_i),
        .wb_valid_o (wb_valid_o),
        .wb_ready_i (wb_ready_i),
        .wb_data_o  (wb_data_o),
        .wb_rd_o    (wb_rd_o),
        .wb_taken_o (wb_taken_o),
        .flags_q_o  (flags_q_o),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] rd;
        logic       t;
    } entry_t;

    entry_t     mq[$];
    logic [3:0] mflags;
    int         nchk  = 0;
    int         nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_model(input logic [2:0] c, input logic [3:0] f);
        logic z, n, cy, v;
        {z, n, cy, v} = f;
        if (c == 3'd0) return 1'b1;
        if (c == 3'd1) return z;
        if (c == 3'd2) return !z;
        if (c == 3'd3) return n;
        if (c == 3'd4) return !n;
        if (c == 3'd5) return cy;
        if (c == 3'd6) return v;
        return 1'b0;
    endfunction

    task automatic check_all();
        entry_t h;
        h = '0;
        if (mq.size() != 0) h = mq[0];
        chk("ready",   32'(ready_o),    32'(mq.size() != 2));
        chk("valid",   32'(wb_valid_o), 32'(mq.size() != 0));
        chk("count",   32'(count_o),    32'(mq.size()));
        chk("flags",   32'(flags_q_o),  32'(mflags));
        chk("data",    32'(wb_data_o),  32'(h.d));
        chk("rd",      32'(wb_rd_o),    32'(h.rd));
        chk("taken",   32'(wb_taken_o), 32'(h.t));
    endtask

    // One clock: predict from pre-edge model state and inputs, then compare.
    task automatic cycle();
        logic   acc, pop;
        entry_t e;
        acc  = rst_ni && valid_i && (mq.size() != 2);
        pop  = rst_ni && (mq.size() != 0) && wb_ready_i;
        e.d  = r_i;
        e.rd = rd_i;
        e.t  = cond_model(cond_i, mflags);
        @(posedge clk_i);
        #1;
        if (!rst_ni) begin
            mq.delete();
            mflags = 4'b0000;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                if (op_i == 3'd1 || op_i == 3'd2) mflags = flags_i;
                else mflags = {(r_i == 8'd0), r_i[7], mflags[1:0]};
            end
        end
        check_all();
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic [3:0] f,
                         input logic [2:0] op, input logic [1:0] rd, input logic [2:0] c,
                         input logic wbr);
        valid_i    = v;
        r_i        = r;
        flags_i    = f;
        op_i       = op;
        rd_i       = rd;
        cond_i     = c;
        wb_ready_i = wbr;
        cycle();
    endtask

    initial begin
        mflags = 4'b0000;
        rst_ni = 1'b0;

        // Reset with valid_i asserted: nothing may be captured.
        drive(1, 8'h55, 4'hF, 3'd1, 2'd1, 3'd0, 1);
        drive(1, 8'h66, 4'hF, 3'd1, 2'd1, 3'd0, 0);
        rst_ni = 1'b1;
        drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);

        // Single ADD with zero result.
        drive(1, 8'h00, 4'b1010, 3'd1, 2'd2, 3'd0, 0);
        chk("add_data",  32'(wb_data_o),  32'h00);
        chk("add_rd",    32'(wb_rd_o),    32'd2);
        chk("add_taken", 32'(wb_taken_o), 32'd1);
        chk("add_flags", 32'(flags_q_o),  32'b1010);
        drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 1);

        // Logic op keeps C/V from the committed flags.
        drive(1, 8'h03, 4'b0010, 3'd1, 2'd0, 3'd0, 1);
        drive(1, 8'h80, 4'b1111, 3'd4, 2'd1, 3'd0, 1);
        chk("and_flags", 32'(flags_q_o), 32'b0110);
        drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 1);

        // Condition ordering: no forwarding of same-cycle flags.
        drive(1, 8'h01, 4'b0000, 3'd1, 2'd0, 3'd0, 1);
        drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 1);
        drive(1, 8'h00, 4'b1000, 3'd2, 2'd1, 3'd1, 0);
        chk("ord_first", 32'(wb_taken_o), 32'd0);
        drive(1, 8'h05, 4'b0000, 3'd0, 2'd2, 3'd1, 0);
        drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 1);
        chk("ord_second", 32'(wb_taken_o), 32'd1);
        drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 1);

        // Backpressure: third transaction held upstream until a slot frees.
        drive(1, 8'h11, 4'h0, 3'd0, 2'd1, 3'd0, 0);
        drive(1, 8'h22, 4'h0, 3'd0, 2'd2, 3'd0, 0);
        drive(1, 8'h33, 4'h0, 3'd0, 2'd3, 3'd0, 0);
        chk("bp_full",  32'(count_o),   32'd2);
        chk("bp_ready", 32'(ready_o),   32'd0);
        chk("bp_head",  32'(wb_data_o), 32'h11);
        drive(1, 8'h33, 4'h0, 3'd0, 2'd3, 3'd0, 1);
        chk("bp_out2", 32'(wb_data_o), 32'h22);
        drive(1, 8'h33, 4'h0, 3'd0, 2'd3, 3'd0, 1);
        chk("bp_out3", 32'(wb_data_o), 32'h33);
        drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 1);

        // Push+pop at count=1, then reset with two entries buffered.
        drive(1, 8'hA1, 4'h0, 3'd0, 2'd1, 3'd0, 0);
        drive(1, 8'hB2, 4'h0, 3'd0, 2'd2, 3'd0, 1);
        chk("pp_count", 32'(count_o),   32'd1);
        chk("pp_head",  32'(wb_data_o), 32'hB2);
        drive(1, 8'hC3, 4'h0, 3'd0, 2'd3, 3'd0, 0);
        rst_ni = 1'b0;
        drive(1, 8'hD4, 4'h0, 3'd0, 2'd0, 3'd0, 1);
        rst_ni = 1'b1;
        chk("mid_rst_count", 32'(count_o),    32'd0);
        chk("mid_rst_valid", 32'(wb_valid_o), 32'd0);
        for (int i = 0; i < 3; i++) drive(0, 8'h00, 4'h0, 3'd0, 2'd0, 3'd0, 1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_ni = ($urandom_range(63) != 0);
            drive(($urandom_range(3) != 0),
                  ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom),
                  4'($urandom), 3'($urandom), 2'($urandom), 3'($urandom),
                  ($urandom_range(2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
